keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 67 ++++++
 rtl/sync2.sv | 27 ++
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: scanner FSM states, key map and seven-segment encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Map an active-low one-hot row pattern and column drive to the key's hex value.
  function automatic logic [3:0] key_map(input logic [3:0] row_n, input logic [3:0] col_n);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    r = 2'd0;
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_n[i]) r = 2'(i);
      if (!col_n[i]) c = 2'(i);
    end
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hF;
      4'hD: code = 4'h0;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Hex digit to seven-segment, bit order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_7seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; both stages reset to all ones (idle, active-low inputs).
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and hex key code output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 500,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       rs;
  logic             one_low_c;
  state_e           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       pat_q, pat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_down_q, key_down_d;

  sync2 #(.WIDTH(4)) u_sync2 (
    .clock (clock),
    .rst_n (rst_n),
    .d_i   (row),
    .q_o   (rs)
  );

  assign one_low_c = ($countones(~rs) == 1);

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_q       <= 4'b1110;
      pat_q       <= 4'b1111;
      div_q       <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
    end
  end

  // Scan / debounce / hold / release sequencing.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    pat_d       = pat_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low_c) begin
            pat_d   = rs;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rs != pat_q) begin
          // Bounce: resume scanning the same column from a fresh slot.
          div_d   = '0;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = key_map(pat_q, col_q);
          key_down_d  = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (rs == 4'b1111) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rs != 4'b1111) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          div_d      = '0;
          key_down_d = 1'b0;
          col_d      = {col_q[2:0], col_q[3]};
          state_d    = ST_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic       clock;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;

  logic [3:0][3:0] keys;  // keys[r][c] = 1 while key at row r, column c is pressed

  int checks;
  int failures;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col[c]) row[r] = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n, output int pulses, output logic [3:0] code);
    pulses = 0;
    code   = key_code;
    repeat (n) begin
      tick();
      if (key_valid) begin
        pulses++;
        code = key_code;
      end
    end
  endtask

  task automatic test_reset();
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL reset_col: got %b expected 1110", col); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h expected 0", key_code); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL reset_down: got %b expected 0", key_down); end
    rst_n = 1'b1;
  endtask

  // Runs straight after reset release so the scan phase is known.
  task automatic test_idle_scan();
    logic [3:0] exp_col;
    for (int k = 0; k < 64; k++) begin
      tick();
      exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
      checks++; if (col !== exp_col) begin failures++; $display("FAIL idle_col k=%0d: got %b expected %b", k, col, exp_col); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL idle_valid k=%0d: got %b expected 0", k, key_valid); end
    end
  endtask

  task automatic test_single_press();
    int p;
    logic [3:0] code;
    keys[1][2] = 1'b1;
    run(40, p, code);
    checks++; if (p !== 1) begin failures++; $display("FAIL press6_pulses: got %0d expected 1", p); end
    checks++; if (code !== 4'h6) begin failures++; $display("FAIL press6_code: got %h expected 6", code); end
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL press6_down: got %b expected 1", key_down); end
    checks++; if (col !== 4'b1011) begin failures++; $display("FAIL press6_col_hold: got %b expected 1011", col); end
    keys[1][2] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (key_valid) begin
        checks++; failures++; $display("FAIL release6_valid k=%0d: got 1 expected 0", k);
      end
      if (k == 9) begin
        checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL release6_down_hold: got %b expected 1", key_down); end
        checks++; if (col !== 4'b1011) begin failures++; $display("FAIL release6_col_hold: got %b expected 1011", col); end
      end
      if (k == 10) begin
        checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL release6_down_fall: got %b expected 0", key_down); end
        checks++; if (col !== 4'b0111) begin failures++; $display("FAIL release6_col_adv: got %b expected 0111", col); end
        checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL release6_code_hold: got %h expected 6", key_code); end
      end
    end
    run(20, p, code);
  endtask

  task automatic test_bounce();
    int p;
    int bp;
    logic [3:0] code;
    bp = 0;
    for (int rep = 0; rep < 6; rep++) begin
      keys[3][0] = 1'b1;
      run(3, p, code);
      bp += p;
      keys[3][0] = 1'b0;
      run(2, p, code);
      bp += p;
    end
    checks++; if (bp !== 0) begin failures++; $display("FAIL bounce_no_pulse: got %0d expected 0", bp); end
    keys[3][0] = 1'b1;
    run(40, p, code);
    checks++; if (p !== 1) begin failures++; $display("FAIL bounceF_pulses: got %0d expected 1", p); end
    checks++; if (code !== 4'hF) begin failures++; $display("FAIL bounceF_code: got %h expected F", code); end
    keys[3][0] = 1'b0;
    run(20, p, code);
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL bounceF_release: got %b expected 0", key_down); end
  endtask

  task automatic test_second_key();
    int p;
    logic [3:0] code;
    keys[0][0] = 1'b1;
    run(40, p, code);
    checks++; if (p !== 1) begin failures++; $display("FAIL key1_pulses: got %0d expected 1", p); end
    checks++; if (code !== 4'h1) begin failures++; $display("FAIL key1_code: got %h expected 1", code); end
    keys[2][3] = 1'b1;
    run(40, p, code);
    checks++; if (p !== 0) begin failures++; $display("FAIL second_key_ignored: got %0d expected 0", p); end
    checks++; if (key_code !== 4'h1) begin failures++; $display("FAIL second_key_code_hold: got %h expected 1", key_code); end
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL second_key_down: got %b expected 1", key_down); end
    keys[0][0] = 1'b0;
    keys[2][3] = 1'b0;
    run(20, p, code);
    checks++; if (p !== 0) begin failures++; $display("FAIL both_release_pulses: got %0d expected 0", p); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL both_release_down: got %b expected 0", key_down); end
    keys[2][3] = 1'b1;
    run(40, p, code);
    checks++; if (p !== 1) begin failures++; $display("FAIL keyC_pulses: got %0d expected 1", p); end
    checks++; if (code !== 4'hC) begin failures++; $display("FAIL keyC_code: got %h expected C", code); end
    keys[2][3] = 1'b0;
    run(20, p, code);
  endtask

  task automatic test_reset_hold();
    int p;
    logic [3:0] code;
    keys[0][0] = 1'b1;
    run(40, p, code);
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL rsthold_pre_down: got %b expected 1", key_down); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rsthold_async_down: got %b expected 0", key_down); end
    checks++; if (col !== 4'b1110) begin failures++; $display("FAIL rsthold_async_col: got %b expected 1110", col); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rsthold_async_code: got %h expected 0", key_code); end
    @(negedge clock);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      tick();
      if (k == 10) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rsthold_early: got %b expected 0", key_valid); end
      end
      if (k == 11) begin
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rsthold_accept: got %b expected 1", key_valid); end
        checks++; if (key_code !== 4'h1) begin failures++; $display("FAIL rsthold_code: got %h expected 1", key_code); end
      end
      if (k == 12) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rsthold_pulse_width: got %b expected 0", key_valid); end
      end
    end
    run(30, p, code);
    checks++; if (p !== 0) begin failures++; $display("FAIL rsthold_no_repeat: got %0d expected 0", p); end
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL rsthold_down: got %b expected 1", key_down); end
    keys[0][0] = 1'b0;
    run(20, p, code);
  endtask

  task automatic test_multi_row();
    int p;
    logic [3:0] seen;
    p    = 0;
    seen = 4'b0000;
    keys[0][1] = 1'b1;
    keys[1][1] = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (key_valid) p++;
      seen = seen | ~col;
    end
    checks++; if (p !== 0) begin failures++; $display("FAIL multirow_pulses: got %0d expected 0", p); end
    checks++; if (seen !== 4'b1111) begin failures++; $display("FAIL multirow_scan: got %b expected 1111", seen); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL multirow_down: got %b expected 0", key_down); end
    keys[0][1] = 1'b0;
    keys[1][1] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    keys     = '0;
    rst_n    = 1'b0;
    test_reset();
    test_idle_scan();
    test_single_press();
    test_bounce();
    test_second_key();
    test_reset_hold();
    test_multi_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
